// File: rtl/sign_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sign_ext_pkg
// Description : Shared width defaults and narrow-range helpers used by the
//               sign-extension and sign-narrowing datapath units.
// Revision    : 1.0 - initial release
// ============================================================================
package sign_ext_pkg;

  localparam int DEFAULT_REG_DATA_WIDTH = 16;
  localparam int DEFAULT_DATA_2_WIDTH   = 4;

  // Largest value representable in a signed field of the given width.
  function automatic int narrow_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic int narrow_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/narrow_fit_check.sv
`default_nettype none
// ============================================================================
// Module      : narrow_fit_check
// Description : Combinational range check. A wide signed value fits a narrow
//               signed field when every bit from the wide MSB down to the
//               narrow sign bit carries the same value.
// Revision    : 1.0 - initial release
// ============================================================================
module narrow_fit_check
  import sign_ext_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DEFAULT_REG_DATA_WIDTH,
  parameter int DATA_2_WIDTH   = DEFAULT_DATA_2_WIDTH
) (
  input  logic [REG_DATA_WIDTH-1:0] data_in,
  output logic                      fit,
  output logic                      sign
);

  // Bits that must all replicate the narrow field's sign bit.
  logic [REG_DATA_WIDTH-DATA_2_WIDTH:0] upper;
  // Low bits carry the narrow magnitude only; they play no part in the check.
  logic [DATA_2_WIDTH-2:0]              unused_low;

  assign upper      = data_in[REG_DATA_WIDTH-1:DATA_2_WIDTH-1];
  assign unused_low = data_in[DATA_2_WIDTH-2:0];

  assign fit  = (&upper) | ~(|upper);
  assign sign = data_in[REG_DATA_WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/sign_narrower.sv
`default_nettype none
// ============================================================================
// Module      : sign_narrower
// Description : Narrows a register-width signed value to a DATA_2_WIDTH
//               signed field through a two-stage valid/ready pipeline.
//               Out-of-range values are flagged and counted (saturating).
//               Build option SIGN_NARROWER_SATURATE_EN: when defined,
//               out-of-range values clamp to max/min; otherwise they wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_narrower
  import sign_ext_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DEFAULT_REG_DATA_WIDTH,
  parameter int DATA_2_WIDTH   = DEFAULT_DATA_2_WIDTH,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_DATA_WIDTH-1:0] data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_2_WIDTH-1:0]   data_out,
  output logic                      out_ovf,
  input  logic                      clr_count,
  output logic [CNT_WIDTH-1:0]      ovf_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                    fit;
  logic                    sign;
  logic                    s1_valid;
  logic [DATA_2_WIDTH-1:0] s1_low;
  logic                    s1_fit;
  logic                    s1_sign;
  logic                    s2_adv;
  logic                    s1_en;
  logic [DATA_2_WIDTH-1:0] narrowed;

  narrow_fit_check #(
    .REG_DATA_WIDTH (REG_DATA_WIDTH),
    .DATA_2_WIDTH   (DATA_2_WIDTH)
  ) u_fit_check (
    .data_in (data_in),
    .fit     (fit),
    .sign    (sign)
  );

  // Stage 2 frees up when empty or being drained; stage 1 then follows.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_adv;
  assign in_ready = s1_en;

`ifdef SIGN_NARROWER_SATURATE_EN
  localparam logic [DATA_2_WIDTH-1:0] SAT_MAX = DATA_2_WIDTH'(narrow_max(DATA_2_WIDTH));
  localparam logic [DATA_2_WIDTH-1:0] SAT_MIN = DATA_2_WIDTH'(narrow_min(DATA_2_WIDTH));

  // Out-of-range values clamp toward the side given by the wide sign bit.
  assign narrowed = s1_fit ? s1_low : (s1_sign ? SAT_MIN : SAT_MAX);
`else
  // Wrapping keeps the low bits regardless of range; the sign is not needed.
  logic unused_sign;
  assign unused_sign = s1_sign;
  assign narrowed    = s1_low;
`endif

  // Stage 1: capture the low field plus range/sign info of an accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_low   <= '0;
      s1_fit   <= 1'b0;
      s1_sign  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_low  <= data_in[DATA_2_WIDTH-1:0];
        s1_fit  <= fit;
        s1_sign <= sign;
      end
    end
  end

  // Stage 2: present the narrowed result, held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_ovf   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= narrowed;
        out_ovf  <= !s1_fit;
      end
    end
  end

  // Overflow event counter: counts handed-off overflow results, sticks at max,
  // and a clear always takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sign_narrower.sv
`default_nettype none
// ============================================================================
// Module      : tb_sign_narrower
// Description : Self-checking bench for sign_narrower (16 -> 4 bits, range
//               -8..7). A transaction-level model predicts every output;
//               directed vectors carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_narrower;

  localparam int REG_W = 16;
  localparam int N_W   = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [REG_W-1:0] data_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N_W-1:0]   data_out;
  logic             out_ovf;
  logic             clr_count = 1'b0;
  logic [CNT_W-1:0] ovf_count;

  int errors = 0;
  int checks = 0;
  bit hs_in;
  bit hs_out;

  always #5 clk = ~clk;

  sign_narrower #(
    .REG_DATA_WIDTH (REG_W),
    .DATA_2_WIDTH   (N_W),
    .CNT_WIDTH      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_ovf   (out_ovf),
    .clr_count (clr_count),
    .ovf_count (ovf_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    logic [N_W-1:0] d;
    logic           ovf;
    longint         edge_n;
  } exp_t;

  exp_t   q[$];
  longint edge_n = 0;
  int     model_cnt = 0;

  function automatic exp_t predict(input logic [REG_W-1:0] x, input longint e);
    exp_t r;
    int v, lo, hi;
    v  = int'($signed(x));
    lo = -(1 << (N_W - 1));
    hi = (1 << (N_W - 1)) - 1;
    r.ovf = (v < lo) || (v > hi);
    r.d   = x[N_W-1:0];
`ifdef SIGN_NARROWER_SATURATE_EN
    if (r.ovf) r.d = (v < 0) ? N_W'(lo) : N_W'(hi);
`endif
    r.edge_n = e;
    return r;
  endfunction

  // Model update on every edge: in-flight words in order, and the counter.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      model_cnt = 0;
    end else begin
      edge_n++;
      if (clr_count)
        model_cnt = 0;
      else if (out_valid && out_ready && q.size() > 0 && q[0].ovf && model_cnt < CNT_MAX)
        model_cnt++;
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(predict(data_in, edge_n));
    end
  end

  // Compare on the falling edge, away from the active edge.
  initial forever begin
    bit exp_v;
    @(negedge clk);
    if (rst_n) begin
      // The oldest word reaches the output one edge after it was accepted.
      exp_v = (q.size() > 0) && (q[0].edge_n < edge_n);
      check("m_out_valid", out_valid, exp_v);
      if (exp_v && out_valid) begin
        check("m_data_out", data_out, q[0].d);
        check("m_out_ovf", out_ovf, q[0].ovf);
      end
      check("m_in_ready", in_ready, (q.size() < 2) || out_ready);
      check("m_ovf_count", ovf_count, model_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    hs_in  = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    #1;
  endtask

  task automatic send_word(input logic [REG_W-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      if (hs_in) done = 1'b1;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // One word through an idle pipe: checks latency and literal result.
  task automatic directed(input string name, input logic [REG_W-1:0] d,
                          input logic [N_W-1:0] exp_d, input logic exp_ovf);
    out_ready = 1'b1;
    send_word(d);
    check({name, "_lat1"}, out_valid, 0);
    tick();
    check({name, "_lat2"}, out_valid, 1);
    check({name, "_data"}, data_out, exp_d);
    check({name, "_ovf"}, out_ovf, exp_ovf);
    tick();
  endtask

  logic [REG_W-1:0] words [4];

  initial begin
    int sent, got, last_i, acc;
    words[0] = 16'd1; words[1] = 16'd2; words[2] = 16'd3; words[3] = 16'd4;

    // Reset state
    #22 rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_ovf_count", ovf_count, 0);
    tick();

    // In-range values, including both range ends
    directed("fit_5", 16'h0005, 4'h5, 1'b0);
    directed("fit_min", 16'hFFF8, 4'h8, 1'b0);
    directed("fit_max", 16'h0007, 4'h7, 1'b0);
`ifdef SIGN_NARROWER_SATURATE_EN
    directed("ovf_8", 16'h0008, 4'h7, 1'b1);
    directed("ovf_8000", 16'h8000, 4'h8, 1'b1);
    directed("ovf_fff7", 16'hFFF7, 4'h8, 1'b1);
`else
    directed("ovf_8", 16'h0008, 4'h8, 1'b1);
    directed("ovf_8000", 16'h8000, 4'h0, 1'b1);
    directed("ovf_fff7", 16'hFFF7, 4'h7, 1'b1);
`endif
    check("cnt_after_3", ovf_count, 3);

    // Backpressure: 6 stalled cycles, then drain in order
    out_ready = 1'b0;
    sent = 0;
    in_valid = 1'b1;
    data_in = words[0];
    for (int i = 0; i < 6; i++) begin
      tick();
      if (hs_in) begin
        sent++;
        if (sent < 4) data_in = words[sent]; else in_valid = 1'b0;
      end
    end
    check("bp_accepted", sent, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_data", data_out, 4'h1);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    got = 0;
    last_i = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      if (out_valid) begin
        check($sformatf("bp_order%0d", got), data_out, got + 1);
        if (got > 0) check("bp_consecutive", i, last_i + 1);
        last_i = i;
        got++;
      end
      tick();
      if (hs_in) begin
        sent++;
        if (sent < 4) data_in = words[sent]; else in_valid = 1'b0;
      end
    end
    check("bp_count", got, 4);
    in_valid = 1'b0;

    // Counter saturation
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("cnt_cleared", ovf_count, 0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    data_in = 16'h0008;
    acc = 0;
    for (int i = 0; i < 400 && acc < 300; i++) begin
      tick();
      if (hs_in) acc++;
    end
    in_valid = 1'b0;
    check("sat_sent", acc, 300);
    tick(); tick(); tick();
    check("cnt_saturated", ovf_count, 255);

    // Clear coincident with an overflow hand-off
    send_word(16'h0008);
    tick();
    check("clr_pending_valid", out_valid, 1);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_handoff", hs_out, 1);
    check("clr_wins", ovf_count, 0);

    // Reset mid-operation with two words in flight
    send_word(16'h0008);
    tick();
    tick();
    check("pre_rst_cnt", ovf_count, 1);
    out_ready = 1'b0;
    send_word(16'h0001);
    send_word(16'h0002);
    check("pre_rst_full", in_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_cnt", ovf_count, 0);
    out_ready = 1'b1;
    #20 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
